wall_span_gen: RTL and testbench

WALL_SPAN_GEN -- requirements
Module: wall_span_gen

---
 rtl/raycast_pkg.sv | 15 +
 rtl/wall_span_gen_if.sv | 34 +++
 rtl/wall_span_calc.sv | 35 +++
 rtl/wall_span_gen.sv | 92 +++++++++
 tb/tb_wall_span_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster constants and types.
// Used by the wall span generator and its height calculator.
package raycast_pkg;

  localparam int SCREEN_H_DEF = 240;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROM_WAIT,
    CALC,
    OUT
  } state_t;

endpackage

// File: rtl/wall_span_gen_if.sv
// Request, ROM and result bundle for the wall span generator.
// slave is the generator side, master the surrounding logic.
interface wall_span_gen_if;

  logic        dist_valid;
  logic        dist_ready;
  logic [9:0]  dist_addr;
  logic [8:0]  dist_col;
  logic [9:0]  rom_addr;
  logic [15:0] rom_idist;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_col;
  logic [7:0]  out_top;
  logic [7:0]  out_bottom;
  logic        out_blank;

  modport slave (
    input  dist_valid, dist_addr, dist_col,
    input  rom_idist, out_ready,
    output dist_ready, rom_addr,
    output out_valid, out_col,
    output out_top, out_bottom, out_blank
  );

  modport master (
    output dist_valid, dist_addr, dist_col,
    output rom_idist, out_ready,
    input  dist_ready, rom_addr,
    input  out_valid, out_col,
    input  out_top, out_bottom, out_blank
  );

endinterface

// File: rtl/wall_span_calc.sv
// Maps a Q8.8 inverse distance to the vertical wall span of one column.
// Purely combinational; height is clamped to the screen.
module wall_span_calc
  import raycast_pkg::*;
#(
  parameter int          SCREEN_H   = SCREEN_H_DEF,
  parameter logic [15:0] WALL_SCALE = 16'd64
) (
  input  logic [15:0] idist,
  output logic [7:0]  top,
  output logic [7:0]  bottom,
  output logic        blank
);

  localparam logic [8:0] SCR  = 9'(SCREEN_H);
  localparam logic [7:0] HALF = 8'(SCREEN_H / 2);

  logic [31:0] prod;
  logic [31:0] raw;
  logic [8:0]  h;
  logic [7:0]  span_top;

  assign prod = 32'(idist) * 32'(WALL_SCALE);
  assign raw  = prod >> FRAC_W;
  assign h    = (raw > 32'(SCREEN_H)) ? SCR : raw[8:0];

  assign blank    = (h == 9'd0);
  assign span_top = 8'((SCR - h) >> 1);

  // a zero-height column collapses onto the horizon row
  assign top    = blank ? HALF : span_top;
  assign bottom = blank ? HALF
                : 8'({1'b0, span_top} + h - 9'd1);

endmodule

// File: rtl/wall_span_gen.sv
// Column request FSM: ROM lookup, span calculation, held result.
// One request in flight; the next is taken only after the result handshake.
module wall_span_gen
  import raycast_pkg::*;
#(
  parameter int          SCREEN_H   = SCREEN_H_DEF,
  parameter logic [15:0] WALL_SCALE = 16'd64
) (
  input  logic           clk,
  input  logic           rst_n,
  wall_span_gen_if.slave bus
);

  state_t      state;
  logic        phase;
  logic [15:0] idist_q;
  logic [8:0]  col_q;
  logic [9:0]  addr_q;
  logic [8:0]  col_o;
  logic [7:0]  top_o;
  logic [7:0]  bot_o;
  logic        blank_o;
  logic [7:0]  c_top;
  logic [7:0]  c_bot;
  logic        c_blank;

  wall_span_calc #(
    .SCREEN_H   (SCREEN_H),
    .WALL_SCALE (WALL_SCALE)
  ) u_calc (
    .idist  (idist_q),
    .top    (c_top),
    .bottom (c_bot),
    .blank  (c_blank)
  );

  // CALC spends one cycle capturing ROM data, one loading results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= 1'b0;
      idist_q <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      col_o   <= '0;
      top_o   <= '0;
      bot_o   <= '0;
      blank_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.dist_valid) begin
            addr_q <= bus.dist_addr;
            col_q  <= bus.dist_col;
            state  <= ROM_WAIT;
          end
        end
        ROM_WAIT: begin
          phase <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          if (!phase) begin
            idist_q <= bus.rom_idist;
            phase   <= 1'b1;
          end else begin
            col_o   <= col_q;
            top_o   <= c_top;
            bot_o   <= c_bot;
            blank_o <= c_blank;
            phase   <= 1'b0;
            state   <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dist_ready = (state == IDLE);
  assign bus.out_valid  = (state == OUT);
  assign bus.rom_addr   = addr_q;
  assign bus.out_col    = col_o;
  assign bus.out_top    = top_o;
  assign bus.out_bottom = bot_o;
  assign bus.out_blank  = blank_o;

endmodule

// File: tb/tb_wall_span_gen.sv
// Scoreboard bench for wall_span_gen with a registered ROM model.
// Expected spans come from a plain arithmetic height/centering model.
module tb_wall_span_gen;

  localparam int H  = 240;
  localparam int WS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wall_span_gen_if bus();

  wall_span_gen #(
    .SCREEN_H   (H),
    .WALL_SCALE (16'd64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] rom [1024];

  always @(posedge clk) bus.rom_idist <= rom[bus.rom_addr];

  typedef struct {
    int col;
    int top;
    int bot;
    int blank;
    int acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int idist, int col, int acc);
    exp_t e;
    int   h;
    h = (idist * WS) / 256;
    if (h > H) h = H;
    e.col = col;
    e.acc = acc;
    if (h == 0) begin
      e.top   = H / 2;
      e.bot   = H / 2;
      e.blank = 1;
    end else begin
      e.top   = (H - h) / 2;
      e.bot   = e.top + h - 1;
      e.blank = 0;
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // acceptance logger and result monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no pending span");
        end else begin
          if (!prev_valid)
            chk("latency", cyc - q[0].acc, 4);
          chk("out_col", int'(bus.out_col), q[0].col);
          chk("out_top", int'(bus.out_top), q[0].top);
          chk("out_bottom", int'(bus.out_bottom), q[0].bot);
          chk("out_blank", int'(bus.out_blank), q[0].blank);
          chk("ready_in_out", int'(bus.dist_ready), 0);
          if (bus.out_ready)
            void'(q.pop_front());
        end
      end
      if (bus.dist_valid && bus.dist_ready) begin
        chk("accept_when_idle", q.size(), 0);
        q.push_back(model(int'(rom[bus.dist_addr]),
                          int'(bus.dist_col), cyc));
      end
    end
    prev_valid <= bus.out_valid;
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready)
      bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [9:0] a, input logic [8:0] c);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.dist_valid = 1'b1;
    bus.dist_addr  = a;
    bus.dist_col   = c;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.dist_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.dist_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance expected dist_ready");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++)
      rom[i] = (i % 7 == 0) ? 16'($urandom)
                            : 16'($urandom_range(0, 16'h0500));
    rom[0]    = 16'h0100;
    rom[1]    = 16'h00FC;
    rom[2]    = 16'h1000;
    rom[3]    = 16'h0004;
    rom[1023] = 16'h0000;

    bus.dist_valid = 1'b0;
    bus.dist_addr  = '0;
    bus.dist_col   = '0;
    bus.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_top", int'(bus.out_top), 0);
    chk("rst_out_bottom", int'(bus.out_bottom), 0);
    chk("rst_out_col", int'(bus.out_col), 0);
    chk("rst_out_blank", int'(bus.out_blank), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_dist_ready", int'(bus.dist_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.dist_ready), 1);
    @(posedge clk);
    #1;

    // directed spans: nominal, odd height, clamp, tiny, zero
    send(10'd0, 9'd5);
    send(10'd1, 9'd300);
    send(10'd2, 9'd17);
    send(10'd3, 9'd100);
    send(10'd1023, 9'd511);
    drain();

    // downstream stall with a competing request
    bus.out_ready = 1'b0;
    send(10'd0, 9'd42);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", int'(bus.out_valid), 1);
    fork
      send(10'd1, 9'd43);
      begin
        repeat (10) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset during ROM_WAIT drops the request
    send(10'd0, 9'd7);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_post_rst", int'(bus.dist_ready), 1);
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(10'd2, 9'd8);
    drain();

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)));
    drain();
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
